// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C init sequencer: opcodes, FSM states and
// the field layout of one command-table word {op, dev, reg, data}.
package i2c_cfg_pkg;

  typedef enum logic [1:0] {
    OP_WRITE        = 2'd0,
    OP_WRITE_VERIFY = 2'd1,
    OP_DELAY        = 2'd2,
    OP_END          = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    WR     = 4'd3,
    RD     = 4'd4,
    CMP    = 4'd5,
    DLY    = 4'd6,
    RETRY  = 4'd7,
    DONE   = 4'd8,
    FAIL   = 4'd9
  } state_e;

  localparam int DATA_LSB = 0;
  localparam int REG_LSB  = 8;

  // Field positions above the register address depend on its width.
  function automatic int dev_lsb(input int reg_addr_w);
    return REG_LSB + reg_addr_w;
  endfunction

  function automatic int op_lsb(input int reg_addr_w);
    return REG_LSB + reg_addr_w + 8;
  endfunction

  function automatic int tbl_w(input int reg_addr_w);
    return 2 + 8 + reg_addr_w + 8;
  endfunction

endpackage

// File: rtl/i2c_cfg_delay.sv
// Loadable down-counter with a zero flag; paces DELAY table entries.
module i2c_cfg_delay #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks an external command table and replays it as I2C master requests,
// with per-entry retry, delay entries and done/error reporting.
module i2c_init_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int REG_ADDR_W = 8,
  parameter int MAX_RETRY  = 2,
  parameter int DELAY_UNIT = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [7:0]                    err_index,
  output logic [$clog2(DEPTH)-1:0]      tbl_addr,
  input  logic [2+8+REG_ADDR_W+8-1:0]   tbl_data,
  output logic                          i2c_write_req,
  output logic                          i2c_read_req,
  input  logic                          i2c_write_req_ack,
  input  logic                          i2c_read_req_ack,
  output logic [7:0]                    i2c_slave_dev_addr,
  output logic [REG_ADDR_W-1:0]         i2c_slave_reg_addr,
  output logic [7:0]                    i2c_write_data,
  input  logic [7:0]                    i2c_read_data,
  input  logic                          i2c_error,
  output state_e                        dbg_state
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int DEV_LSB = dev_lsb(REG_ADDR_W);
  localparam int OP_LSB  = op_lsb(REG_ADDR_W);
  localparam int CNT_W   = $clog2(255 * DELAY_UNIT + 1);

  state_e             state;
  logic [IDX_W-1:0]   index;
  logic [2:0]         retry_cnt;
  op_e                op_q;
  logic [7:0]         rd_data;
  op_e                tbl_op;
  logic [CNT_W-1:0]   dly_val;
  logic               dly_load;
  logic               dly_zero;
  logic               entry_ok;

  assign tbl_addr  = index;
  assign dbg_state = state;
  assign tbl_op    = op_e'(tbl_data[OP_LSB +: 2]);
  assign dly_val   = CNT_W'(tbl_data[DATA_LSB +: 8]) * CNT_W'(DELAY_UNIT);
  assign dly_load  = (state == DECODE) && (tbl_op == OP_DELAY);

  i2c_cfg_delay #(.W(CNT_W)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dly_load),
    .load_val (dly_val),
    .en       (state == DLY),
    .zero     (dly_zero)
  );

  // Handshake: a req rises with its operands stable and stays high until the
  // matching ack is sampled while req is high; req drops on the next cycle.
  // An ack seen while req is low means nothing and is ignored.
  always_comb begin
    entry_ok = 1'b0;
    case (state)
      WR:  entry_ok = i2c_write_req && i2c_write_req_ack && !i2c_error &&
                      (op_q != OP_WRITE_VERIFY);
      CMP: entry_ok = (rd_data == i2c_write_data);
      DLY: entry_ok = dly_zero;
      default: entry_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      index              <= '0;
      retry_cnt          <= '0;
      op_q               <= OP_WRITE;
      rd_data            <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      err_index          <= '0;
      i2c_write_req      <= 1'b0;
      i2c_read_req       <= 1'b0;
      i2c_slave_dev_addr <= '0;
      i2c_slave_reg_addr <= '0;
      i2c_write_data     <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
            index     <= '0;
            retry_cnt <= '0;
            state     <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          i2c_slave_dev_addr <= tbl_data[DEV_LSB +: 8];
          i2c_slave_reg_addr <= tbl_data[REG_LSB +: REG_ADDR_W];
          i2c_write_data     <= tbl_data[DATA_LSB +: 8];
          op_q               <= tbl_op;
          case (tbl_op)
            OP_WRITE, OP_WRITE_VERIFY: begin
              i2c_write_req <= 1'b1;
              state         <= WR;
            end
            OP_DELAY: state <= DLY;
            default: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          endcase
        end
        WR: begin
          if (i2c_write_req && i2c_write_req_ack) begin
            i2c_write_req <= 1'b0;
            if (i2c_error) begin
              state <= RETRY;
            end else if (op_q == OP_WRITE_VERIFY) begin
              i2c_read_req <= 1'b1;
              state        <= RD;
            end
          end
        end
        RD: begin
          if (i2c_read_req && i2c_read_req_ack) begin
            i2c_read_req <= 1'b0;
            rd_data      <= i2c_read_data;
            state        <= i2c_error ? RETRY : CMP;
          end
        end
        CMP: begin
          if (rd_data != i2c_write_data) state <= RETRY;
        end
        DLY: ;
        RETRY: begin
          if (retry_cnt < 3'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 1'b1;
            state     <= FETCH;
          end else begin
            err_index <= 8'(index);
            error     <= 1'b1;
            busy      <= 1'b0;
            state     <= FAIL;
          end
        end
        default: state <= IDLE;
      endcase

      // A finished entry moves on, or ends the run after the last table slot.
      if (entry_ok) begin
        retry_cnt <= '0;
        if (index == IDX_W'(DEPTH - 1)) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end else begin
          index <= index + 1'b1;
          state <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: table memory, randomized-latency I2C slave,
// transaction log and a table-level reference model of the expected run.
module tb_i2c_init_sequencer;

  localparam int MAX_RETRY = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, error;
  logic [7:0]  err_index;
  logic [1:0]  tbl_addr;
  logic [25:0] tbl_data;
  logic        i2c_write_req, i2c_read_req;
  logic        i2c_write_req_ack, i2c_read_req_ack;
  logic [7:0]  i2c_slave_dev_addr;
  logic [7:0]  i2c_slave_reg_addr;
  logic [7:0]  i2c_write_data;
  logic [7:0]  i2c_read_data;
  logic        i2c_error;
  i2c_cfg_pkg::state_e dbg_state;

  i2c_init_sequencer #(
    .DEPTH(4), .REG_ADDR_W(8), .MAX_RETRY(MAX_RETRY), .DELAY_UNIT(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .error(error), .err_index(err_index), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .i2c_write_req(i2c_write_req), .i2c_read_req(i2c_read_req),
    .i2c_write_req_ack(i2c_write_req_ack), .i2c_read_req_ack(i2c_read_req_ack),
    .i2c_slave_dev_addr(i2c_slave_dev_addr), .i2c_slave_reg_addr(i2c_slave_reg_addr),
    .i2c_write_data(i2c_write_data), .i2c_read_data(i2c_read_data),
    .i2c_error(i2c_error), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- table memory (one-cycle read latency) ----------------
  logic [25:0] tbl_mem [4];
  always @(posedge clk) tbl_data <= tbl_mem[tbl_addr];

  // ---------------- slave model ----------------
  int lat_max  = 3;
  int resp_err = 0;
  bit rd_bad   = 1'b0;
  bit hold_off = 1'b0;

  initial begin
    bit is_rd;
    forever begin
      @(negedge clk);
      if (rst_n && !hold_off && (i2c_write_req || i2c_read_req)) begin
        is_rd = i2c_read_req;
        repeat ($urandom_range(0, lat_max)) @(negedge clk);
        if (is_rd) begin
          i2c_read_data    = i2c_write_data ^ {7'b0, rd_bad};
          i2c_read_req_ack = 1'b1;
        end else begin
          i2c_write_req_ack = 1'b1;
        end
        if (resp_err > 0) begin
          i2c_error = 1'b1;
          resp_err--;
        end
        @(negedge clk);
        i2c_write_req_ack = 1'b0;
        i2c_read_req_ack  = 1'b0;
        i2c_error         = 1'b0;
      end
    end
  end

  // ---------------- transaction log: {is_write, dev, reg, data} ----------------
  logic [24:0] obs_q[$];
  int          wr_rise_q[$];
  int          overlap_cnt = 0;

  initial begin
    bit wr_prev = 1'b0, rd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (i2c_write_req && i2c_read_req) overlap_cnt++;
      if (i2c_write_req && !wr_prev) begin
        obs_q.push_back({1'b1, i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data});
        wr_rise_q.push_back(cyc);
      end
      if (i2c_read_req && !rd_prev)
        obs_q.push_back({1'b0, i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data});
      wr_prev = i2c_write_req;
      rd_prev = i2c_read_req;
    end
  end

  // ---------------- reference model ----------------
  logic [24:0] exp_q[$];
  bit          exp_done, exp_error;
  logic [7:0]  exp_err_index;

  // Replays the table entry by entry: each I2C ack consumes one injected
  // error; a failed entry is retried up to MAX_RETRY times before aborting.
  task automatic model_run(input int k_err, input bit bad_read);
    int err_left = k_err;
    int tries;
    bit ok;
    logic [1:0] op;
    exp_q.delete();
    exp_done = 1'b0; exp_error = 1'b0; exp_err_index = '0;
    for (int idx = 0; idx < 4; idx++) begin
      op = tbl_mem[idx][25:24];
      if (op == 2'd3) begin
        exp_done = 1'b1;
        return;
      end
      tries = 0;
      forever begin
        ok = 1'b1;
        if (op != 2'd2) begin
          exp_q.push_back({1'b1, tbl_mem[idx][23:0]});
          if (err_left > 0) begin
            err_left--; ok = 1'b0;
          end else if (op == 2'd1) begin
            exp_q.push_back({1'b0, tbl_mem[idx][23:0]});
            if (err_left > 0) begin
              err_left--; ok = 1'b0;
            end else if (bad_read) begin
              ok = 1'b0;
            end
          end
        end
        if (ok) break;
        if (tries == MAX_RETRY) begin
          exp_error = 1'b1;
          exp_err_index = 8'(idx);
          return;
        end
        tries++;
      end
    end
    exp_done = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  // Pulses start, optionally pokes start again poke_at cycles later, and
  // waits (bounded) for the run to settle in done or error.
  task automatic run_seq(input int poke_at, output bit timed_out);
    obs_q.delete();
    wr_rise_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      start = (i == poke_at);
      if (!busy && (done || error)) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic set_table(input logic [25:0] e0, e1, e2, e3);
    tbl_mem[0] = e0; tbl_mem[1] = e1; tbl_mem[2] = e2; tbl_mem[3] = e3;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)          begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)          begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (error !== 1'b0)         begin bad++; $display("FAIL reset_error got=%b want=0", error); end
    total++; if (i2c_write_req !== 1'b0) begin bad++; $display("FAIL reset_wreq got=%b want=0", i2c_write_req); end
    total++; if (i2c_read_req !== 1'b0)  begin bad++; $display("FAIL reset_rreq got=%b want=0", i2c_read_req); end
    total++; if (err_index !== 8'h00)    begin bad++; $display("FAIL reset_err_index got=%h want=00", err_index); end
    total++; if (tbl_addr !== 2'd0)      begin bad++; $display("FAIL reset_tbl_addr got=%0d want=0", tbl_addr); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL no_autostart_busy got=%b want=0", busy); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL no_autostart_req got=%0d want=0", obs_q.size()); end
  endtask

  task automatic test_two_writes();
    bit to;
    set_table({2'd0, 8'h72, 8'h08, 8'h35}, {2'd0, 8'h7A, 8'h2F, 8'h00}, {2'd3, 24'h0}, {2'd3, 24'h0});
    resp_err = 0; rd_bad = 1'b0; lat_max = 3;
    model_run(0, 1'b0);
    run_seq(-1, to);
    total++; if (to) begin bad++; $display("FAIL two_writes_timeout got=busy want=settled"); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL two_writes_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL two_writes_txn%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (done !== 1'b1)  begin bad++; $display("FAIL two_writes_done got=%b want=1", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL two_writes_error got=%b want=0", error); end
  endtask

  task automatic test_write_verify();
    bit to;
    set_table({2'd1, 8'h60, 8'h05, 8'h10}, {2'd3, 24'h0}, {2'd3, 24'h0}, {2'd3, 24'h0});
    for (int pass = 0; pass < 2; pass++) begin
      resp_err = 0; rd_bad = (pass == 1); lat_max = 2;
      model_run(0, rd_bad);
      run_seq(-1, to);
      total++; if (to) begin bad++; $display("FAIL wv%0d_timeout got=busy want=settled", pass); end
      total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL wv%0d_count got=%0d want=%0d", pass, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL wv%0d_txn%0d got=%h want=%h", pass, i, obs_q[i], exp_q[i]); end
      end
      total++; if (done !== exp_done)   begin bad++; $display("FAIL wv%0d_done got=%b want=%b", pass, done, exp_done); end
      total++; if (error !== exp_error) begin bad++; $display("FAIL wv%0d_error got=%b want=%b", pass, error, exp_error); end
      if (exp_error) begin
        total++; if (err_index !== exp_err_index) begin bad++; $display("FAIL wv%0d_err_index got=%h want=%h", pass, err_index, exp_err_index); end
      end
    end
    rd_bad = 1'b0;
  endtask

  task automatic test_bus_error_retry();
    bit to;
    set_table({2'd0, 8'h72, 8'h08, 8'h35}, {2'd3, 24'h0}, {2'd3, 24'h0}, {2'd3, 24'h0});
    resp_err = 1; rd_bad = 1'b0; lat_max = 3;
    model_run(1, 1'b0);
    run_seq(-1, to);
    total++; if (to) begin bad++; $display("FAIL bus_err_timeout got=busy want=settled"); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bus_err_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bus_err_txn%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (done !== 1'b1)  begin bad++; $display("FAIL bus_err_done got=%b want=1", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL bus_err_error got=%b want=0", error); end
  endtask

  // The DELAY entry's cost is isolated by comparing against a zero delay.
  task automatic test_delay();
    bit to;
    int gap [2];
    logic [7:0] dly [2] = '{8'd0, 8'd3};
    for (int pass = 0; pass < 2; pass++) begin
      set_table({2'd0, 8'h50, 8'h01, 8'hAA}, {2'd2, 16'h0, dly[pass]}, {2'd0, 8'h50, 8'h02, 8'hBB}, {2'd3, 24'h0});
      resp_err = 0; rd_bad = 1'b0; lat_max = 0;
      model_run(0, 1'b0);
      run_seq(-1, to);
      gap[pass] = 0;
      total++; if (to || wr_rise_q.size() != 2) begin bad++; $display("FAIL delay%0d_writes got=%0d want=2", pass, wr_rise_q.size()); end
      else gap[pass] = wr_rise_q[1] - wr_rise_q[0];
      total++; if (done !== 1'b1) begin bad++; $display("FAIL delay%0d_done got=%b want=1", pass, done); end
    end
    total++;
    if ((gap[1] - gap[0]) < 29 || (gap[1] - gap[0]) > 31) begin
      bad++; $display("FAIL delay_cycles got=%0d want=30", gap[1] - gap[0]);
    end
    lat_max = 3;
  endtask

  task automatic test_depth_no_end();
    bit to;
    set_table({2'd0, 8'h10, 8'h00, 8'h01}, {2'd0, 8'h10, 8'h01, 8'h02},
              {2'd0, 8'h10, 8'h02, 8'h03}, {2'd0, 8'h10, 8'h03, 8'h04});
    resp_err = 0; rd_bad = 1'b0; lat_max = 3;
    model_run(0, 1'b0);
    run_seq(6, to);
    total++; if (to) begin bad++; $display("FAIL depth_timeout got=busy want=settled"); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL depth_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL depth_txn%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL depth_done got=%b want=1", done); end
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b0 || obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL depth_no_rerun got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_transfer();
    bit to;
    bit seen;
    int n;
    set_table({2'd0, 8'h72, 8'h08, 8'h35}, {2'd3, 24'h0}, {2'd3, 24'h0}, {2'd3, 24'h0});
    resp_err = 0; rd_bad = 1'b0; hold_off = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (i2c_write_req) seen = 1'b1;
      else @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL rst_mid_req_seen got=0 want=1"); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (i2c_write_req !== 1'b0) begin bad++; $display("FAIL rst_mid_wreq got=%b want=0", i2c_write_req); end
    total++; if (busy !== 1'b0)          begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; hold_off = 1'b0;
    n = obs_q.size();
    repeat (20) @(negedge clk);
    total++; if (obs_q.size() != n) begin bad++; $display("FAIL rst_mid_no_resume got=%0d want=%0d", obs_q.size(), n); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got=%b%b want=00", busy, done); end
    model_run(0, 1'b0);
    run_seq(-1, to);
    total++; if (to || done !== 1'b1) begin bad++; $display("FAIL rst_mid_restart_done got=%b want=1", done); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rst_mid_restart_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    bit to;
    logic [1:0] op;
    int k;
    for (int it = 0; it < 10; it++) begin
      for (int e = 0; e < 4; e++) begin
        op = 2'($urandom_range(0, 3));
        if (op == 2'd3 && $urandom_range(0, 2) != 0) op = 2'd1;
        tbl_mem[e] = {op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      (op == 2'd2) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255))};
      end
      k = $urandom_range(0, 3);
      resp_err = k; rd_bad = ($urandom_range(0, 3) == 0); lat_max = 3;
      model_run(k, rd_bad);
      run_seq(-1, to);
      total++; if (to) begin bad++; $display("FAIL rand%0d_timeout got=busy want=settled", it); end
      total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", it, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_txn%0d got=%h want=%h", it, i, obs_q[i], exp_q[i]); end
      end
      total++; if (done !== exp_done || error !== exp_error) begin
        bad++; $display("FAIL rand%0d_status got=%b%b want=%b%b", it, done, error, exp_done, exp_error);
      end
      if (exp_error) begin
        total++; if (err_index !== exp_err_index) begin bad++; $display("FAIL rand%0d_err_index got=%h want=%h", it, err_index, exp_err_index); end
      end
    end
    rd_bad = 1'b0; resp_err = 0;
  endtask

  task automatic test_req_exclusive();
    total++; if (overlap_cnt != 0) begin bad++; $display("FAIL req_exclusive got=%0d want=0", overlap_cnt); end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    start             = 1'b0;
    i2c_write_req_ack = 1'b0;
    i2c_read_req_ack  = 1'b0;
    i2c_read_data     = 8'h00;
    i2c_error         = 1'b0;
    set_table({2'd3, 24'h0}, {2'd3, 24'h0}, {2'd3, 24'h0}, {2'd3, 24'h0});
    test_reset();
    test_two_writes();
    test_write_verify();
    test_bus_error_retry();
    test_delay();
    test_depth_no_end();
    test_reset_mid_transfer();
    test_random();
    test_req_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
